// File: rtl/thor2025_rat.sv
// thor2025_rat: 3-lane register alias table with intra-group bypass and circular checkpoint buffer
// Ports: clk/rst (async, active-high); stall holds map and outputs.
//   Per lane n: vn/wrn/rdn/won/rsna/rsnb in; psna/psnb/pdoldn/ovn registered out.
//   chkpt -> chkpt_id, restore/restore_id roll back, chk_release frees the oldest slot,
//   chk_full flags all slots in use, chk_ovf pulses when a checkpoint is refused.
module thor2025_rat #(
    parameter int AREGS = 64,
    parameter int PREG = 96,
    parameter int NCHK = 4,
    localparam int AW = $clog2(AREGS),
    localparam int TW = $clog2(PREG),
    localparam int CW = $clog2(NCHK)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          v0,
    input  logic          v1,
    input  logic          v2,
    input  logic          wr0,
    input  logic          wr1,
    input  logic          wr2,
    input  logic [AW-1:0] rd0,
    input  logic [AW-1:0] rd1,
    input  logic [AW-1:0] rd2,
    input  logic [TW-1:0] wo0,
    input  logic [TW-1:0] wo1,
    input  logic [TW-1:0] wo2,
    input  logic [AW-1:0] rs0a,
    input  logic [AW-1:0] rs0b,
    input  logic [AW-1:0] rs1a,
    input  logic [AW-1:0] rs1b,
    input  logic [AW-1:0] rs2a,
    input  logic [AW-1:0] rs2b,
    output logic [TW-1:0] ps0a,
    output logic [TW-1:0] ps0b,
    output logic [TW-1:0] ps1a,
    output logic [TW-1:0] ps1b,
    output logic [TW-1:0] ps2a,
    output logic [TW-1:0] ps2b,
    output logic [TW-1:0] pdold0,
    output logic [TW-1:0] pdold1,
    output logic [TW-1:0] pdold2,
    output logic          ov0,
    output logic          ov1,
    output logic          ov2,
    input  logic          chkpt,
    output logic [CW-1:0] chkpt_id,
    input  logic          restore,
    input  logic [CW-1:0] restore_id,
    input  logic          chk_release,
    output logic          chk_full,
    output logic          chk_ovf
);
    logic [2:0]    v, wr, we, ov;
    logic [AW-1:0] rd [3];
    logic [AW-1:0] rsa [3];
    logic [AW-1:0] rsb [3];
    logic [TW-1:0] wo [3];
    logic [TW-1:0] pa [3];
    logic [TW-1:0] pb [3];
    logic [TW-1:0] po [3];
    logic [TW-1:0] psa_q [3];
    logic [TW-1:0] psb_q [3];
    logic [TW-1:0] pdo_q [3];
    logic [TW-1:0] map [AREGS];
    logic [TW-1:0] nmap [AREGS];
    logic [TW-1:0] snap [NCHK][AREGS];
    logic [CW-1:0] head, tail, head_n, tail_r;
    logic [CW:0]   count, cnt_r;
    logic          acc, take, rel;

    assign v = {v2, v1, v0};
    assign wr = {wr2, wr1, wr0};
    assign rd = '{rd0, rd1, rd2};
    assign wo = '{wo0, wo1, wo2};
    assign rsa = '{rs0a, rs1a, rs2a};
    assign rsb = '{rs0b, rs1b, rs2b};
    // r0 writes are dropped entirely so they can neither bypass nor update the map
    assign we = v & wr & {rd2 != '0, rd1 != '0, rd0 != '0};

    function automatic logic [CW-1:0] inc(input logic [CW-1:0] x);
        return x == CW'(NCHK - 1) ? '0 : x + 1'b1;
    endfunction

    assign chk_full = count == (CW+1)'(NCHK);
    assign acc = !stall && !restore;
    assign take = acc && chkpt && !chk_full;
    assign rel = chk_release && count != '0;
    assign head_n = rel ? inc(head) : head;
    assign tail_r = inc(restore_id);
    // restore_id remains allocated: live slots run from the (post-release) head up to restore_id
    assign cnt_r = (CW+1)'(restore_id) - (CW+1)'(head_n) + (restore_id >= head_n ? '0 : (CW+1)'(NCHK)) + 1'b1;

    // Later lanes in the loop overwrite earlier hits, so the nearest earlier writer wins
    always_comb begin
        nmap = map;
        for (int n = 0; n < 3; n++) begin
            pa[n] = rsa[n] == '0 ? '0 : map[rsa[n]];
            pb[n] = rsb[n] == '0 ? '0 : map[rsb[n]];
            po[n] = rd[n] == '0 ? '0 : map[rd[n]];
            for (int m = 0; m < n; m++) begin
                if (we[m] && rd[m] == rsa[n]) pa[n] = wo[m];
                if (we[m] && rd[m] == rsb[n]) pb[n] = wo[m];
                if (we[m] && rd[m] == rd[n]) po[n] = wo[m];
            end
            if (we[n]) nmap[rd[n]] = wo[n];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < AREGS; i++) map[i] <= TW'(i);
            for (int n = 0; n < 3; n++) begin
                psa_q[n] <= '0;
                psb_q[n] <= '0;
                pdo_q[n] <= '0;
            end
            ov <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
            chkpt_id <= '0;
            chk_ovf <= 1'b0;
        end else begin
            chk_ovf <= acc && chkpt && chk_full;
            head <= head_n;
            if (restore) begin
                map <= snap[restore_id];
                ov <= '0;
                tail <= tail_r;
                count <= cnt_r;
            end else begin
                if (acc) begin
                    map <= nmap;
                    psa_q <= pa;
                    psb_q <= pb;
                    pdo_q <= po;
                    ov <= v;
                end
                if (take) begin
                    chkpt_id <= tail;
                    tail <= inc(tail);
                end
                count <= count + (CW+1)'(take) - (CW+1)'(rel);
            end
        end
    end

    // Snapshot holds the map including this group's own writes
    always_ff @(posedge clk) begin
        if (take && !rst) snap[tail] <= nmap;
    end

    assign ps0a = psa_q[0];
    assign ps1a = psa_q[1];
    assign ps2a = psa_q[2];
    assign ps0b = psb_q[0];
    assign ps1b = psb_q[1];
    assign ps2b = psb_q[2];
    assign pdold0 = pdo_q[0];
    assign pdold1 = pdo_q[1];
    assign pdold2 = pdo_q[2];
    assign {ov2, ov1, ov0} = ov;
endmodule

// File: tb/tb_thor2025_rat.sv
// tb_thor2025_rat: directed self-checking bench for thor2025_rat
module tb_thor2025_rat;
    logic clk, rst, stall;
    logic v0, v1, v2, wr0, wr1, wr2;
    logic [5:0] rd0, rd1, rd2, rs0a, rs0b, rs1a, rs1b, rs2a, rs2b;
    logic [6:0] wo0, wo1, wo2;
    logic [6:0] ps0a, ps0b, ps1a, ps1b, ps2a, ps2b, pdold0, pdold1, pdold2;
    logic ov0, ov1, ov2;
    logic chkpt, restore, chk_release, chk_full, chk_ovf;
    logic [1:0] chkpt_id, restore_id;
    int tests = 0;
    int fails = 0;

    thor2025_rat dut (
        .clk(clk), .rst(rst), .stall(stall),
        .v0(v0), .v1(v1), .v2(v2), .wr0(wr0), .wr1(wr1), .wr2(wr2),
        .rd0(rd0), .rd1(rd1), .rd2(rd2), .wo0(wo0), .wo1(wo1), .wo2(wo2),
        .rs0a(rs0a), .rs0b(rs0b), .rs1a(rs1a), .rs1b(rs1b), .rs2a(rs2a), .rs2b(rs2b),
        .ps0a(ps0a), .ps0b(ps0b), .ps1a(ps1a), .ps1b(ps1b), .ps2a(ps2a), .ps2b(ps2b),
        .pdold0(pdold0), .pdold1(pdold1), .pdold2(pdold2),
        .ov0(ov0), .ov1(ov1), .ov2(ov2),
        .chkpt(chkpt), .chkpt_id(chkpt_id), .restore(restore), .restore_id(restore_id),
        .chk_release(chk_release), .chk_full(chk_full), .chk_ovf(chk_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear();
        {stall, chkpt, restore, chk_release, restore_id} = '0;
        {v0, v1, v2, wr0, wr1, wr2} = '0;
        {rd0, rd1, rd2, rs0a, rs0b, rs1a, rs1b, rs2a, rs2b} = '0;
        {wo0, wo1, wo2} = '0;
    endtask

    task automatic lane(input int n, input logic vv, input logic ww, input logic [5:0] r,
                        input logic [6:0] w, input logic [5:0] a, input logic [5:0] b);
        case (n)
            0: begin v0 = vv; wr0 = ww; rd0 = r; wo0 = w; rs0a = a; rs0b = b; end
            1: begin v1 = vv; wr1 = ww; rd1 = r; wo1 = w; rs1a = a; rs1b = b; end
            default: begin v2 = vv; wr2 = ww; rd2 = r; wo2 = w; rs2a = a; rs2b = b; end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear();
        step();
        step();
        tests++; if ({ov0, ov1, ov2} !== 3'b000) begin fails++; $display("FAIL reset_ov got %b exp 000", {ov0, ov1, ov2}); end
        tests++; if (ps0a !== 7'd0 || pdold2 !== 7'd0) begin fails++; $display("FAIL reset_tags got %0d/%0d exp 0/0", ps0a, pdold2); end
        tests++; if (chk_full !== 1'b0 || chk_ovf !== 1'b0 || chkpt_id !== 2'd0) begin fails++; $display("FAIL reset_chk got %b%b%0d exp 000", chk_full, chk_ovf, chkpt_id); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        clear();
        lane(0, 1, 0, 0, 0, 5, 0);
        lane(1, 0, 0, 0, 0, 63, 0);
        step();
        tests++; if (ps0a !== 7'd5) begin fails++; $display("FAIL basic_ps0a got %0d exp 5", ps0a); end
        tests++; if (ps0b !== 7'd0) begin fails++; $display("FAIL basic_ps0b got %0d exp 0", ps0b); end
        tests++; if (ov0 !== 1'b1 || ov1 !== 1'b0) begin fails++; $display("FAIL basic_ov got %b%b exp 10", ov0, ov1); end
        tests++; if (ps1a !== 7'd63) begin fails++; $display("FAIL basic_ps1a got %0d exp 63", ps1a); end
    endtask

    task automatic test_bypass();
        clear();
        lane(0, 1, 1, 3, 70, 0, 0);
        lane(1, 1, 0, 0, 0, 3, 4);
        lane(2, 1, 1, 3, 72, 3, 0);
        step();
        tests++; if (ps1a !== 7'd70) begin fails++; $display("FAIL byp_ps1a got %0d exp 70", ps1a); end
        tests++; if (ps1b !== 7'd4) begin fails++; $display("FAIL byp_ps1b got %0d exp 4", ps1b); end
        tests++; if (ps2a !== 7'd70) begin fails++; $display("FAIL byp_ps2a got %0d exp 70", ps2a); end
        tests++; if (pdold0 !== 7'd3) begin fails++; $display("FAIL byp_pdold0 got %0d exp 3", pdold0); end
        tests++; if (pdold2 !== 7'd70) begin fails++; $display("FAIL byp_pdold2 got %0d exp 70", pdold2); end
        clear();
        lane(0, 1, 0, 0, 0, 3, 0);
        step();
        tests++; if (ps0a !== 7'd72) begin fails++; $display("FAIL byp_next_r3 got %0d exp 72", ps0a); end
        clear();
        lane(0, 1, 1, 9, 10, 0, 0);
        lane(1, 1, 1, 9, 11, 0, 0);
        lane(2, 1, 0, 0, 0, 9, 0);
        step();
        tests++; if (ps2a !== 7'd11) begin fails++; $display("FAIL byp_nearest got %0d exp 11", ps2a); end
        tests++; if (pdold1 !== 7'd10 || pdold0 !== 7'd9) begin fails++; $display("FAIL byp_pdold got %0d/%0d exp 10/9", pdold1, pdold0); end
        clear();
        lane(0, 1, 0, 0, 0, 9, 3);
        step();
        tests++; if (ps0a !== 7'd11 || ps0b !== 7'd72) begin fails++; $display("FAIL byp_highest got %0d/%0d exp 11/72", ps0a, ps0b); end
    endtask

    task automatic test_checkpoint();
        clear();
        lane(0, 1, 1, 7, 80, 0, 0);
        chkpt = 1'b1;
        step();
        tests++; if (chkpt_id !== 2'd0 || chk_full !== 1'b0) begin fails++; $display("FAIL chk_id got %0d/%b exp 0/0", chkpt_id, chk_full); end
        clear();
        lane(0, 1, 1, 7, 81, 7, 0);
        step();
        tests++; if (ps0a !== 7'd80) begin fails++; $display("FAIL chk_r7_pre got %0d exp 80", ps0a); end
        clear();
        lane(0, 1, 1, 7, 90, 7, 0);
        restore = 1'b1;
        restore_id = 2'd0;
        step();
        tests++; if (ov0 !== 1'b0) begin fails++; $display("FAIL restore_ov got %b exp 0", ov0); end
        clear();
        lane(0, 1, 0, 0, 0, 7, 0);
        step();
        tests++; if (ps0a !== 7'd80 || ov0 !== 1'b1) begin fails++; $display("FAIL restore_r7 got %0d/%b exp 80/1", ps0a, ov0); end
    endtask

    task automatic test_full();
        clear();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chkpt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++; if (chkpt_id !== 2'(i)) begin fails++; $display("FAIL full_id%0d got %0d exp %0d", i, chkpt_id, i); end
        end
        tests++; if (chk_full !== 1'b1 || chk_ovf !== 1'b0) begin fails++; $display("FAIL full_flag got %b%b exp 10", chk_full, chk_ovf); end
        step();
        tests++; if (chk_ovf !== 1'b1 || chkpt_id !== 2'd3) begin fails++; $display("FAIL ovf_pulse got %b/%0d exp 1/3", chk_ovf, chkpt_id); end
        chkpt = 1'b0;
        step();
        tests++; if (chk_ovf !== 1'b0 || chk_full !== 1'b1) begin fails++; $display("FAIL ovf_clear got %b%b exp 01", chk_ovf, chk_full); end
        chk_release = 1'b1;
        step();
        tests++; if (chk_full !== 1'b0) begin fails++; $display("FAIL release_full got %b exp 0", chk_full); end
        chk_release = 1'b0;
        chkpt = 1'b1;
        step();
        tests++; if (chkpt_id !== 2'd0 || chk_full !== 1'b1) begin fails++; $display("FAIL wrap_id got %0d/%b exp 0/1", chkpt_id, chk_full); end
        chkpt = 1'b0;
        restore = 1'b1;
        restore_id = 2'd2;
        step();
        tests++; if (chk_full !== 1'b0) begin fails++; $display("FAIL restore_full got %b exp 0", chk_full); end
        restore = 1'b0;
        chkpt = 1'b1;
        step();
        tests++; if (chkpt_id !== 2'd3 || chk_full !== 1'b0) begin fails++; $display("FAIL restore_tail got %0d/%b exp 3/0", chkpt_id, chk_full); end
        step();
        tests++; if (chkpt_id !== 2'd0 || chk_full !== 1'b1) begin fails++; $display("FAIL restore_count got %0d/%b exp 0/1", chkpt_id, chk_full); end
    endtask

    task automatic test_stall();
        clear();
        lane(0, 1, 1, 5, 50, 6, 0);
        step();
        tests++; if (ps0a !== 7'd6 || pdold0 !== 7'd5) begin fails++; $display("FAIL stall_pre got %0d/%0d exp 6/5", ps0a, pdold0); end
        stall = 1'b1;
        lane(0, 1, 1, 5, 51, 5, 0);
        lane(1, 1, 0, 0, 0, 5, 0);
        step();
        tests++; if (ps0a !== 7'd6 || pdold0 !== 7'd5 || ov0 !== 1'b1 || ov1 !== 1'b0) begin fails++; $display("FAIL stall_hold got %0d/%0d/%b%b exp 6/5/10", ps0a, pdold0, ov0, ov1); end
        clear();
        lane(0, 1, 1, 0, 99, 5, 0);
        lane(1, 1, 0, 0, 0, 0, 5);
        step();
        tests++; if (ps0a !== 7'd50) begin fails++; $display("FAIL stall_nomap got %0d exp 50", ps0a); end
        tests++; if (pdold0 !== 7'd0 || ps1a !== 7'd0) begin fails++; $display("FAIL r0_wr got %0d/%0d exp 0/0", pdold0, ps1a); end
        tests++; if (ps1b !== 7'd50) begin fails++; $display("FAIL r0_ps1b got %0d exp 50", ps1b); end
        clear();
        lane(0, 1, 0, 0, 0, 0, 5);
        step();
        tests++; if (ps0a !== 7'd0 || ps0b !== 7'd50) begin fails++; $display("FAIL r0_read got %0d/%0d exp 0/50", ps0a, ps0b); end
    endtask

    task automatic test_reset_mid();
        clear();
        lane(0, 1, 0, 0, 0, 5, 0);
        step();
        tests++; if (ps0a !== 7'd50 || ov0 !== 1'b1) begin fails++; $display("FAIL mid_pre got %0d/%b exp 50/1", ps0a, ov0); end
        #2 rst = 1'b1;
        #1;
        tests++; if (ps0a !== 7'd0 || ov0 !== 1'b0) begin fails++; $display("FAIL mid_async got %0d/%b exp 0/0", ps0a, ov0); end
        rst = 1'b0;
        step();
        tests++; if (ps0a !== 7'd5 || ov0 !== 1'b1) begin fails++; $display("FAIL mid_identity got %0d/%b exp 5/1", ps0a, ov0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_checkpoint();
        test_full();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
